// File: rtl/display_pkg.sv
// Shared types, segment table and helpers for the multiplexed score display.
package display_pkg;

  // All segments off (active-low pins).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One packed decimal digit.
  typedef logic [3:0] bcd_t;

  // Sequential binary-to-BCD converter states.
  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_LOAD   = 2'd1,
    CONV_SHIFT  = 2'd2,
    CONV_COMMIT = 2'd3
  } conv_state_t;

  // Active-low {g,f,e,d,c,b,a} patterns for the digits 0..9.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Digit to segment pattern; non-decimal codes show nothing.
  function automatic logic [6:0] bcd_to_seg(input bcd_t d);
    logic [6:0] s;
    s = SEG_BLANK;
    if (d <= 4'd9) s = SEG_TABLE[d];
    return s;
  endfunction

  // 10^n, used for the saturation threshold.
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Bit-serial double-dabble converter: one bit per cycle, saturating to all 9s
// when the value does not fit in DIGITS_PER_FIELD decimal digits.
//
// Handshake: while start is high the converter loops LOAD -> SHIFT -> COMMIT.
// value is sampled only on the LOAD cycle; done is high for exactly the COMMIT
// cycle, and bcd/saturated are valid (and final) only while done is high.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VAL_W            = 7,
  parameter int DIGITS_PER_FIELD = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [VAL_W-1:0]                  value,
  output logic                              done,
  output bcd_t [DIGITS_PER_FIELD-1:0]       bcd,
  output logic                              saturated,
  output conv_state_t                       dbg_state
);

  localparam int          CNT_W = $clog2(VAL_W + 1);
  localparam int          SR_W  = 4 * DIGITS_PER_FIELD + VAL_W;
  localparam logic [31:0] LIMIT = 32'(pow10(DIGITS_PER_FIELD));

  conv_state_t                     state, state_nxt;
  logic [VAL_W-1:0]                bin_sr;
  bcd_t [DIGITS_PER_FIELD-1:0]     bcd_sr;
  bcd_t [DIGITS_PER_FIELD-1:0]     adj;
  logic [SR_W-1:0]                 shifted;
  logic [CNT_W-1:0]                bit_cnt;
  logic                            sat;
  logic [31:0]                     value_ext;

  assign value_ext = 32'(value);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CONV_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE only right after reset, then a fixed-length loop.
  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:   if (start) state_nxt = CONV_LOAD;
      CONV_LOAD:   state_nxt = CONV_SHIFT;
      CONV_SHIFT:  if (bit_cnt == CNT_W'(VAL_W - 1)) state_nxt = CONV_COMMIT;
      CONV_COMMIT: state_nxt = start ? CONV_LOAD : CONV_IDLE;
      default:     state_nxt = CONV_IDLE;
    endcase
  end

  // Add-3 correction on every digit >= 5 before the next shift.
  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < DIGITS_PER_FIELD; i++) begin
      if (bcd_sr[i] >= 4'd5) adj[i] = bcd_sr[i] + 4'd3;
    end
  end

  // Upper digits are dropped; the lower digits stay exact (value mod 10^D),
  // and anything that overflows them is replaced by all 9s at commit.
  assign shifted = {adj, bin_sr} << 1;

  // Datapath: sample on LOAD, one shift-and-add-3 step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        CONV_LOAD: begin
          bin_sr  <= value;
          bcd_sr  <= '0;
          bit_cnt <= '0;
          sat     <= (value_ext >= LIMIT);
        end
        CONV_SHIFT: begin
          bcd_sr  <= shifted[SR_W-1:VAL_W];
          bin_sr  <= shifted[VAL_W-1:0];
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign done      = (state == CONV_COMMIT);
  assign saturated = sat;
  assign bcd       = sat ? {DIGITS_PER_FIELD{4'd9}} : bcd_sr;
  assign dbg_state = state;

endmodule

// File: rtl/score_display_mux.sv
// Multiplexed seven-segment scan driver for NUM_FIELDS decimal values, with
// round-robin BCD conversion, leading-zero blanking, per-field blink and a
// frame tick.
module score_display_mux
  import display_pkg::*;
#(
  parameter int NUM_FIELDS       = 2,
  parameter int DIGITS_PER_FIELD = 2,
  parameter int VAL_W            = 7,
  parameter int REFRESH_DIV      = 8192,
  parameter int BLINK_LOG2       = 24
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_FIELDS*VAL_W-1:0]            values,
  input  logic                                   blank_lz,
  input  logic [NUM_FIELDS-1:0]                  blink_mask,
  output logic [NUM_FIELDS*DIGITS_PER_FIELD-1:0] an,
  output logic [6:0]                             seg,
  output logic                                   frame_tick
);

  localparam int ND   = NUM_FIELDS * DIGITS_PER_FIELD;
  localparam int FI_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int P_W  = (ND > 1) ? $clog2(ND) : 1;
  localparam int R_W  = $clog2(REFRESH_DIV);

  logic [FI_W-1:0]                  fidx;
  logic [VAL_W-1:0]                 cur_value;
  logic                             conv_done;
  logic                             conv_sat;
  bcd_t [DIGITS_PER_FIELD-1:0]      conv_bcd;
  conv_state_t                      conv_state;

  bcd_t [DIGITS_PER_FIELD-1:0]      disp     [NUM_FIELDS];
  bcd_t [DIGITS_PER_FIELD-1:0]      disp_nxt [NUM_FIELDS];

  logic [R_W-1:0]                   ref_cnt, ref_nxt;
  logic                             ref_last;
  logic [P_W-1:0]                   pos, pos_nxt;
  logic [BLINK_LOG2:0]              blink_cnt, blink_nxt;
  logic                             blink_phase;
  logic [ND-1:0]                    an_nxt;
  logic [6:0]                       seg_nxt;
  logic                             zero_run;

  assign cur_value = values[fidx*VAL_W +: VAL_W];

  bin2bcd_seq #(
    .VAL_W            (VAL_W),
    .DIGITS_PER_FIELD (DIGITS_PER_FIELD)
  ) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (1'b1),
    .value     (cur_value),
    .done      (conv_done),
    .bcd       (conv_bcd),
    .saturated (conv_sat),
    .dbg_state (conv_state)
  );

  // A commit only ever happens from the COMMIT state with a legal payload.
  always @(posedge clk) begin
    if (rst_n && conv_done)
      assert (conv_state == CONV_COMMIT &&
              (!conv_sat || conv_bcd == {DIGITS_PER_FIELD{4'd9}}));
  end

  // Digit registers as they will be after this edge (commit bypass).
  always_comb begin
    disp_nxt = disp;
    if (conv_done) disp_nxt[fidx] = conv_bcd;
  end

  // Field round-robin and atomic per-field digit update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fidx <= '0;
      disp <= '{default: '0};
    end else begin
      disp <= disp_nxt;
      if (conv_done) fidx <= (fidx == FI_W'(NUM_FIELDS - 1)) ? '0 : fidx + FI_W'(1);
    end
  end

  // Refresh divider, scan position and blink counter next values.
  always_comb begin
    ref_last    = (ref_cnt == R_W'(REFRESH_DIV - 1));
    ref_nxt     = ref_last ? '0 : ref_cnt + R_W'(1);
    pos_nxt     = pos;
    if (ref_last) pos_nxt = (pos == P_W'(ND - 1)) ? '0 : pos + P_W'(1);
    blink_nxt   = blink_cnt + 1'b1;
    blink_phase = blink_nxt[BLINK_LOG2];
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      pos       <= '0;
      blink_cnt <= '0;
    end else begin
      ref_cnt   <= ref_nxt;
      pos       <= pos_nxt;
      blink_cnt <= blink_nxt;
    end
  end

  // Anode and segment pattern for the position being shown after this edge.
  always_comb begin
    an_nxt          = '1;
    an_nxt[pos_nxt] = 1'b0;
    seg_nxt         = SEG_BLANK;
    zero_run        = 1'b1;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      zero_run = 1'b1;
      for (int d = DIGITS_PER_FIELD - 1; d >= 0; d--) begin
        zero_run = zero_run && (disp_nxt[f][d] == 4'd0);
        if (pos_nxt == P_W'(f * DIGITS_PER_FIELD + d)) begin
          if ((blink_mask[f] && blink_phase) || (blank_lz && zero_run && d != 0))
            seg_nxt = SEG_BLANK;
          else
            seg_nxt = bcd_to_seg(disp_nxt[f][d]);
        end
      end
    end
  end

  // Output registers; tick marks the cycle anode 0 turns on for a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_tick <= (pos_nxt == '0) && an[0];
    end
  end

endmodule
